// File: rtl/core_pkg.sv
// Back-end shared types and widths: PRF geometry and the writeback request record.
package core_pkg;
  localparam int DATA_W = 16;
  localparam int PREG_W = 5;
  localparam int N_PREG = 1 << PREG_W;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_find_first.sv
// One-hot first set bit of mask_i at or after ptr_i, wrapping modulo N.
module rr_find_first #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     mask_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     first_o
);
  logic             found;
  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    first_o = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(N)) pos = pos - (PTR_W+1)'(N);
      idx = pos[PTR_W-1:0];
      if (!found && mask_i[idx]) begin
        first_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prf_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to N_WP results per cycle onto registered PRF write ports.
// Optional WB_ARB_STATS_EN adds saturating grant / conflict counters.
module prf_wb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_WP   = 2,
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int PREG_W = core_pkg::PREG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][PREG_W-1:0]  req_preg,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_WP-1:0]               prf_we,
  output logic [N_WP-1:0][PREG_W-1:0]   prf_waddr,
  output logic [N_WP-1:0][DATA_W-1:0]   prf_wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_grants,
  output logic [31:0]                   stat_conflicts
`endif
);
  import core_pkg::*;

  localparam int PTR_W = ptr_w(N_REQ);

  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [N_WP:0][N_REQ-1:0]   avail;
  logic [N_WP-1:0][N_REQ-1:0] gnt_oh;
  wb_req_t [N_WP-1:0]         port_q, port_d;

  // Flush and reset simply hide every request, so no stage can grant.
  assign avail[0]  = (flush || !rst) ? '0 : req_valid;
  assign req_ready = avail[0] & ~avail[N_WP];

  for (genvar k = 0; k < N_WP; k++) begin : g_port
    rr_find_first #(.N(N_REQ), .PTR_W(PTR_W)) u_ff (
      .mask_i (avail[k]),
      .ptr_i  (rr_ptr_q),
      .first_o(gnt_oh[k])
    );
    assign avail[k+1]   = avail[k] & ~gnt_oh[k];
    assign prf_we[k]    = port_q[k].valid;
    assign prf_waddr[k] = port_q[k].preg;
    assign prf_wdata[k] = port_q[k].data;
  end

  // Ports fill in order, so the highest busy port holds the last grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < N_WP; k++) begin
      port_d[k]       = port_q[k];
      port_d[k].valid = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_oh[k][i]) begin
          port_d[k].valid = 1'b1;
          port_d[k].preg  = req_preg[i];
          port_d[k].data  = req_data[i];
          rr_ptr_d        = (i == N_REQ-1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
    if (flush) rr_ptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      port_q   <= port_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0]    stat_grants_q, stat_grants_d, stat_conflicts_q, stat_conflicts_d;
  logic [PTR_W:0] gcnt;
  logic [32:0]    gsum;

  always_comb begin
    gcnt = '0;
    for (int i = 0; i < N_REQ; i++) gcnt = gcnt + (PTR_W+1)'(req_ready[i]);
    gsum             = {1'b0, stat_grants_q} + 33'(gcnt);
    stat_grants_d    = gsum[32] ? '1 : gsum[31:0];
    stat_conflicts_d = stat_conflicts_q;
    if (!flush && |(req_valid & ~req_ready) && !(&stat_conflicts_q))
      stat_conflicts_d = stat_conflicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants_q    <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_grants_q    <= stat_grants_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end

  assign stat_grants    = stat_grants_q;
  assign stat_conflicts = stat_conflicts_q;
`endif
endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Scoreboard bench for prf_wb_arbiter (4 requesters, 2 write ports).
module tb_prf_wb_arbiter;
  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic [3:0]           req_valid, req_ready;
  logic [3:0][4:0]      req_preg;
  logic [3:0][15:0]     req_data;
  logic [1:0]           prf_we;
  logic [1:0][4:0]      prf_waddr;
  logic [1:0][15:0]     prf_wdata;
`ifdef WB_ARB_STATS_EN
  logic [31:0]          stat_grants, stat_conflicts;
`endif

  int          n_pass = 0, n_total = 0;
  logic [43:0] sb[$];
  logic [43:0] e;
  logic [1:0]  m_ptr;
  logic [3:0]  m_pend;
  logic [4:0]  m_addr[2];
  logic [15:0] m_data[2];
  bit          hold_data;
  int unsigned m_grants, m_confl;
  logic [3:0]  got, exp;

  prf_wb_arbiter #(.N_REQ(4), .N_WP(2), .DATA_W(16), .PREG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_preg(req_preg), .req_data(req_data),
    .req_ready(req_ready),
    .prf_we(prf_we), .prf_waddr(prf_waddr), .prf_wdata(prf_wdata)
`ifdef WB_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset();
    m_ptr = '0; m_pend = '0; m_grants = 0; m_confl = 0;
    for (int k = 0; k < 2; k++) begin m_addr[k] = '0; m_data[k] = '0; end
    sb.delete();
  endtask

  // Drives one cycle at posedge+1, samples req_ready mid-cycle, predicts the
  // registered write ports and returns at the following posedge+1.
  task automatic step(input logic [3:0] v, input logic fl,
                      output logic [3:0] g, output logic [3:0] x);
    logic [1:0] we;
    int cnt, last, idx;
    n_total++;
    if (|(m_pend & ~v)) $display("FAIL protocol_drop: pending=%b valid=%b", m_pend, v);
    else n_pass++;
    for (int i = 0; i < 4; i++)
      if (!m_pend[i] && !hold_data) req_data[i] = 16'($urandom);
    req_valid = v; flush = fl;
    #4;
    g = req_ready;
    x = '0; we = '0; cnt = 0; last = 0;
    if (!fl)
      for (int j = 0; j < 4; j++) begin
        idx = (int'(m_ptr) + j) % 4;
        if (v[idx] && cnt < 2) begin
          x[idx] = 1'b1; we[cnt] = 1'b1;
          m_addr[cnt] = req_preg[idx]; m_data[cnt] = req_data[idx];
          last = idx; cnt++;
        end
      end
    n_total++;
    if (cnt == 2 && m_addr[0] == m_addr[1]) $display("FAIL dup_tag: both ports carry tag %0d", m_addr[0]);
    else n_pass++;
    sb.push_back({we, m_addr[1], m_addr[0], m_data[1], m_data[0]});
    m_grants += cnt;
    if (!fl && |(v & ~x)) m_confl++;
    m_ptr  = fl ? 2'd0 : (cnt > 0 ? 2'((last + 1) % 4) : m_ptr);
    m_pend = fl ? 4'b0 : (v & ~x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; req_valid = 4'b1111; hold_data = 0;
    req_preg = {5'd13, 5'd7, 5'd11, 5'd10};
    req_data = '0;
    model_reset();
    #12;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_total++;
    if ({prf_we, prf_waddr, prf_wdata} !== 44'd0) $display("FAIL reset_ports: got %h want 0", {prf_we, prf_waddr, prf_wdata});
    else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    step(4'b1111, 1'b0, got, exp);
    n_total++;
    if (got !== exp || got !== 4'b0011) $display("FAIL reset_first_grant: got %b want 0011", got); else n_pass++;
    e = sb.pop_front(); n_total++;
    if ({prf_we, prf_waddr, prf_wdata} !== e) $display("FAIL reset_first_wb: got %h want %h", {prf_we, prf_waddr, prf_wdata}, e);
    else n_pass++;
    step(4'b1100, 1'b0, got, exp);
    e = sb.pop_front(); n_total++;
    if (got !== 4'b1100 || {prf_we, prf_waddr, prf_wdata} !== e)
      $display("FAIL reset_drain: ready %b wb %h want 1100 %h", got, {prf_we, prf_waddr, prf_wdata}, e);
    else n_pass++;
  endtask

  task automatic test_single();
    hold_data = 1; req_data[2] = 16'h1234;
    step(4'b0100, 1'b0, got, exp);
    hold_data = 0;
    n_total++;
    if (got !== 4'b0100) $display("FAIL single_ready: got %b want 0100", got); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (prf_we !== 2'b01 || prf_waddr[0] !== 5'd7 || prf_wdata[0] !== 16'h1234 || {prf_we, prf_waddr, prf_wdata} !== e)
      $display("FAIL single_wb: we=%b addr0=%0d data0=%h want we=01 addr0=7 data0=1234", prf_we, prf_waddr[0], prf_wdata[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    step(4'b1011, 1'b0, got, exp);
    n_total++;
    if (got !== 4'b1001) $display("FAIL wrap_ready: got %b want 1001", got); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (prf_waddr[0] !== 5'd13 || prf_waddr[1] !== 5'd10 || {prf_we, prf_waddr, prf_wdata} !== e)
      $display("FAIL wrap_wb: addr0=%0d addr1=%0d want 13 10", prf_waddr[0], prf_waddr[1]);
    else n_pass++;
    step(4'b0010, 1'b0, got, exp);
    e = sb.pop_front(); n_total++;
    if (got !== 4'b0010 || {prf_we, prf_waddr, prf_wdata} !== e)
      $display("FAIL wrap_next: ready %b want 0010", got);
    else n_pass++;
  endtask

  task automatic test_flush();
    step(4'b1111, 1'b1, got, exp);
    n_total++;
    if (got !== 4'b0000) $display("FAIL flush_ready: got %b want 0000", got); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (prf_we !== 2'b00 || {prf_we, prf_waddr, prf_wdata} !== e) $display("FAIL flush_we: got %b want 00", prf_we);
    else n_pass++;
    step(4'b1111, 1'b0, got, exp);
    e = sb.pop_front(); n_total++;
    if (got !== 4'b0011 || {prf_we, prf_waddr, prf_wdata} !== e) $display("FAIL flush_after: ready %b want 0011", got);
    else n_pass++;
    step(4'b1100, 1'b0, got, exp);
    e = sb.pop_front(); n_total++;
    if (got !== 4'b1100 || {prf_we, prf_waddr, prf_wdata} !== e) $display("FAIL flush_drain: ready %b want 1100", got);
    else n_pass++;
  endtask

  task automatic test_full_load();
    logic [3:0] want_g[3] = '{4'b0011, 4'b1100, 4'b0011};
    logic [4:0] want_p0[3] = '{5'd10, 5'd7, 5'd10};
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 1'b0, got, exp);
      e = sb.pop_front(); n_total++;
      if (got !== want_g[c] || prf_waddr[0] !== want_p0[c] || prf_we !== 2'b11 || {prf_we, prf_waddr, prf_wdata} !== e)
        $display("FAIL full_load[%0d]: ready %b addr0 %0d want %b %0d", c, got, prf_waddr[0], want_g[c], want_p0[c]);
      else n_pass++;
    end
    step(4'b1100, 1'b0, got, exp);
    e = sb.pop_front(); n_total++;
    if (got !== 4'b1100 || {prf_we, prf_waddr, prf_wdata} !== e) $display("FAIL full_drain: ready %b want 1100", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int wt[4] = '{0, 0, 0, 0};
    logic fl;
    for (int c = 0; c < 40; c++) begin
      fl = ($urandom_range(9) == 0);
      step(m_pend | 4'($urandom), fl, got, exp);
      n_total++;
      if (got !== exp) $display("FAIL b2b_ready[%0d]: got %b want %b", c, got, exp); else n_pass++;
      e = sb.pop_front(); n_total++;
      if ({prf_we, prf_waddr, prf_wdata} !== e)
        $display("FAIL b2b_wb[%0d]: got %h want %h", c, {prf_we, prf_waddr, prf_wdata}, e);
      else n_pass++;
      for (int i = 0; i < 4; i++) wt[i] = (fl || !req_valid[i] || got[i]) ? 0 : wt[i] + 1;
      n_total++;
      if (wt[0] > 1 || wt[1] > 1 || wt[2] > 1 || wt[3] > 1)
        $display("FAIL fairness[%0d]: waits %0d %0d %0d %0d exceed 1", c, wt[0], wt[1], wt[2], wt[3]);
      else n_pass++;
    end
`ifdef WB_ARB_STATS_EN
    n_total++;
    if (stat_grants !== m_grants || stat_conflicts !== m_confl)
      $display("FAIL stats: grants %0d conflicts %0d want %0d %0d", stat_grants, stat_conflicts, m_grants, m_confl);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    step(4'b1111, 1'b0, got, exp);
    e = sb.pop_front(); n_total++;
    if (prf_we !== 2'b11 || {prf_we, prf_waddr, prf_wdata} !== e) $display("FAIL async_pre: we %b want 11", prf_we);
    else n_pass++;
    #2; rst = 1'b0; #1;
    n_total++;
    if ({prf_we, prf_waddr, prf_wdata} !== 44'd0 || req_ready !== 4'b0000)
      $display("FAIL async_reset: wb %h ready %b want 0 0000", {prf_we, prf_waddr, prf_wdata}, req_ready);
    else n_pass++;
`ifdef WB_ARB_STATS_EN
    n_total++;
    if (stat_grants !== 32'd0 || stat_conflicts !== 32'd0)
      $display("FAIL async_stats: %0d %0d want 0 0", stat_grants, stat_conflicts);
    else n_pass++;
`endif
    req_valid = '0;
    @(posedge clk); #1; rst = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_flush();
    test_full_load();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
